inst_rom: RTL
=============

INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter: ADDR_W, default 8, log2 of word depth (256 x 16-bit words).
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rom_ce_i  in  1  fetch enable from the PC stage.
REQ-005 SHALL have port: rom_addr_i  in  16  instruction word address; bits [ADDR_W-1:0] used, upper bits ignored.
REQ-006 SHALL have port: rom_data_o  out  16  fetched instruction.
REQ-007 SHALL have port: ld_start_i  in  1  one-cycle pulse starting a program load.
REQ-008 SHALL have port: ld_byte_i  in  8  loader byte stream.
REQ-009 SHALL have port: ld_valid_i  in  1  ld_byte_i valid.
REQ-010 SHALL have port: ld_ready_o  out  1  block accepts a byte this cycle.
REQ-011 SHALL have port: ld_busy_o  out  1  load in progress.
REQ-012 SHALL have port: ld_done_o  out  1  one-cycle pulse at load completion.
REQ-013 SHALL have port: ld_count_o  out  ADDR_W+1  words written by the current or last load.

Function
REQ-014 Fetch SHALL be registered: rom_ce_i=1 in cycle n -> rom_data_o = mem[rom_addr_i] in cycle n+1.
REQ-015 rom_ce_i=0 or ld_busy_o=1 in cycle n SHALL give rom_data_o = 16'h0000 (NOP) in cycle n+1.
REQ-016 Loader FSM states SHALL be IDLE, LEN, HI, LO, DONE.
REQ-017 IDLE: ld_start_i=1 -> LEN; clear write pointer and ld_count_o. ld_start_i outside IDLE SHALL be ignored.
REQ-018 A byte SHALL be accepted only when ld_valid_i=1 and ld_ready_o=1; ld_ready_o=1 exactly in LEN, HI, LO.
REQ-019 LEN: accepted byte sets word count N; value 0 means 2^ADDR_W; -> HI.
REQ-020 HI: accepted byte latched as instruction bits [15:8]; -> LO.
REQ-021 LO: accepted byte forms bits [7:0]; word written to mem[write pointer] the same edge; pointer and ld_count_o increment; -> DONE if ld_count_o reaches N, else HI.
REQ-022 DONE: ld_done_o=1 for exactly one cycle; -> IDLE. ld_busy_o=1 in LEN, HI, LO, DONE.
REQ-023 Stalled ld_valid_i (0) SHALL hold state indefinitely; no timeout.
REQ-024 Write pointer SHALL wrap at 2^ADDR_W; reaching N ends the load first, so no overwrite occurs within one load.
REQ-025 Fetch result in the cycle after ld_busy_o falls SHALL reflect newly loaded contents.

Reset
REQ-026 rst=0 SHALL asynchronously force: FSM=IDLE, rom_data_o=0, ld_ready_o=0, ld_busy_o=0, ld_done_o=0, ld_count_o=0, pointer=0.
REQ-027 Memory array SHALL NOT be reset; contents survive reset.
REQ-028 Reset mid-load SHALL abandon the load; words already written stay written.

Configuration
REQ-029 Macro INST_ROM_CHECKSUM_EN, when defined, SHALL add port ld_csum_o  out  16: wrapping 16-bit sum of all words written in the current load, cleared on accepted ld_start_i and on reset, stable after ld_done_o.
REQ-030 Without INST_ROM_CHECKSUM_EN the port and adder SHALL not exist; all other behaviour identical.

Structure
REQ-031 Loader state enum and NOP constant (16'h0000) SHALL live in the shared defines package; instruction width SHALL use the existing InstBus definition.
REQ-032 Loader FSM SHALL be sub-module inst_rom_loader (FSM, pointer, count, checksum); inst_rom holds the array and fetch register.

Verification
REQ-033 Reset, then load N=2 bytes 02,34,43,12,34 -> mem[0]=16'h3443, mem[1]=16'h1234, ld_done_o one pulse, ld_count_o=2.
REQ-034 After REQ-033 load, ce=1 addr=1 -> rom_data_o=16'h1234 next cycle; ce=0 -> 16'h0000 next cycle.
REQ-035 Load with ld_valid_i gaps of 3 cycles between bytes and ld_start_i re-pulsed during HI -> same result as REQ-033, restart ignored.
REQ-036 Fetch with ce=1 during load -> rom_data_o=16'h0000 throughout ld_busy_o.
REQ-037 rst=0 asserted in LO after 1 word -> FSM IDLE, outputs zero, mem[0] retained, mem[1] unchanged.
REQ-038 With INST_ROM_CHECKSUM_EN: load words 16'hFFFF,16'h0002 -> ld_csum_o=16'h0001.

Source files
------------

// File: rtl/inst_rom_pkg.sv
// Shared definitions for the instruction ROM: instruction bus type, NOP encoding,
// loader state encoding and state-decode helpers.
package inst_rom_pkg;

  localparam int INST_W = 16;

  typedef logic [INST_W-1:0] InstBus;

  localparam InstBus NOP = 16'h0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    DONE = 3'd4
  } ld_state_e;

  function automatic logic state_ready(input ld_state_e s);
    return (s == LEN) || (s == HI) || (s == LO);
  endfunction

  function automatic logic state_busy(input ld_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/inst_rom_if.sv
// Fetch and loader bus of inst_rom; ld_csum_o exists only with INST_ROM_CHECKSUM_EN.
interface inst_rom_if #(parameter int ADDR_W = 8);
  import inst_rom_pkg::*;

  logic            rom_ce_i;
  logic [15:0]     rom_addr_i;
  InstBus          rom_data_o;
  logic            ld_start_i;
  logic [7:0]      ld_byte_i;
  logic            ld_valid_i;
  logic            ld_ready_o;
  logic            ld_busy_o;
  logic            ld_done_o;
  logic [ADDR_W:0] ld_count_o;
`ifdef INST_ROM_CHECKSUM_EN
  InstBus          ld_csum_o;
`endif

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_byte_i, ld_valid_i,
    output rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_count_o
`ifdef INST_ROM_CHECKSUM_EN
    , ld_csum_o
`endif
  );

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_byte_i, ld_valid_i,
    input  rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_count_o
`ifdef INST_ROM_CHECKSUM_EN
    , ld_csum_o
`endif
  );

endinterface

// File: rtl/inst_rom_loader.sv
// Byte-stream program loader: length byte then big-endian 16-bit words.
// Optional running checksum under INST_ROM_CHECKSUM_EN.
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output InstBus            o_wr_data
`ifdef INST_ROM_CHECKSUM_EN
  ,
  output InstBus            o_csum
`endif
);

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_len;
  logic [7:0]        r_hi;
  logic              w_accept;
  logic              w_start_ok;
  logic [ADDR_W:0]   w_count_inc;
  logic [ADDR_W:0]   w_len;

  assign w_accept    = i_valid & r_ready;
  assign w_start_ok  = (r_state == IDLE) & i_start;
  assign w_count_inc = r_count + (ADDR_W+1)'(1);
  // A zero length byte stands for a full-depth load.
  assign w_len       = (i_byte == 8'h00) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(i_byte);

  assign o_wr_en   = (r_state == LO) & w_accept;
  assign o_wr_addr = r_ptr;
  assign o_wr_data = {r_hi, i_byte};
  assign o_ready   = r_ready;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_count   = r_count;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = LEN; else w_state_nxt = IDLE;
      LEN:     if (w_accept) w_state_nxt = HI; else w_state_nxt = LEN;
      HI:      if (w_accept) w_state_nxt = LO; else w_state_nxt = HI;
      LO: begin
        if (w_accept) begin
          if (w_count_inc == r_len) w_state_nxt = DONE;
          else                      w_state_nxt = HI;
        end else begin
          w_state_nxt = LO;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= state_ready(w_state_nxt);
      r_busy  <= state_busy(w_state_nxt);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Pointer, count, length and high-byte datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_hi    <= 8'h00;
    end else begin
      if (w_start_ok) begin
        r_ptr   <= '0;
        r_count <= '0;
      end
      if ((r_state == LEN) && w_accept) r_len <= w_len;
      if ((r_state == HI) && w_accept)  r_hi  <= i_byte;
      if (o_wr_en) begin
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_count <= w_count_inc;
      end
    end
  end

`ifdef INST_ROM_CHECKSUM_EN
  InstBus r_csum;

  assign o_csum = r_csum;

  // Wrapping sum of the words written by the current load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= NOP;
    end else if (w_start_ok) begin
      r_csum <= NOP;
    end else if (o_wr_en) begin
      r_csum <= r_csum + o_wr_data;
    end else begin
      r_csum <= r_csum;
    end
  end
`endif

endmodule

// File: rtl/inst_rom.sv
// Loadable instruction ROM: non-reset word array, registered fetch port and loader.
// Define INST_ROM_CHECKSUM_EN to add the ld_csum_o load checksum.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  inst_rom_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  InstBus            r_mem [DEPTH];
  InstBus            r_rom_data;
  logic              w_busy;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  InstBus            w_wr_data;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_rd_addr      = bus.rom_addr_i[ADDR_W-1:0];
  assign bus.rom_data_o = r_rom_data;
  assign bus.ld_busy_o  = w_busy;

  inst_rom_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk       (clk),
    .rst       (rst),
    .i_start   (bus.ld_start_i),
    .i_byte    (bus.ld_byte_i),
    .i_valid   (bus.ld_valid_i),
    .o_ready   (bus.ld_ready_o),
    .o_busy    (w_busy),
    .o_done    (bus.ld_done_o),
    .o_count   (bus.ld_count_o),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data)
`ifdef INST_ROM_CHECKSUM_EN
    ,
    .o_csum    (bus.ld_csum_o)
`endif
  );

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  // Registered fetch; NOP while disabled or while a load owns the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_data <= NOP;
    end else if (bus.rom_ce_i && !w_busy) begin
      r_rom_data <= r_mem[w_rd_addr];
    end else begin
      r_rom_data <= NOP;
    end
  end

endmodule
